// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolation sequencer.
// State encoding, ratio encoding and FIFO sizing.
package interp_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;
  localparam int PH_W       = 4;

  localparam logic [CNT_W-1:0] CNT_FULL =
    CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_STOPPING
  } state_e;

  typedef enum logic [1:0] {
    RATIO_2  = 2'd0,
    RATIO_4  = 2'd1,
    RATIO_8  = 2'd2,
    RATIO_16 = 2'd3
  } ratio_e;

  // Last phase index R-1 for R = 2^(r+1).
  function automatic logic [PH_W-1:0]
    ratio_last(input logic [1:0] r);
    logic [PH_W-1:0] v;
    v = '0;
    unique case (ratio_e'(r))
      RATIO_2:  v = 4'd1;
      RATIO_4:  v = 4'd3;
      RATIO_8:  v = 4'd7;
      RATIO_16: v = 4'd15;
      default:  v = 4'd1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/interp_fifo2.sv
// Two-entry sample FIFO; entry 0 is always the head.
// Ports: push/din, pop, flush, count, head.
module interp_fifo2
  import interp_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] r_e0;
  logic [DATA_W-1:0] r_e1;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_push;
  logic              w_pop;

  assign w_push = push && (r_cnt != CNT_FULL);
  assign w_pop  = pop && (r_cnt != '0);
  assign count  = r_cnt;
  assign head   = r_e0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == '0) r_e0 <= din;
          else             r_e1 <= din;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        2'b11: begin
          if (r_cnt == CNT_W'(1)) begin
            r_e0 <= din;
          end else begin
            r_e0 <= r_e1;
            r_e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/interp_seq_ctrl.sv
// Tick/phase sequencer feeding a zero-stuff upsampler.
// In: start/stop/cfg/s_*; out: up_*, busy, underrun.
module interp_seq_ctrl
  import interp_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_ratio,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              up_en,
  output logic              up_load,
  output logic [DATA_W-1:0] up_data,
  output logic              busy,
  output logic              underrun,
  output logic [7:0]        underrun_cnt,
  input  logic              clr_underrun
);

  state_e            r_state;
  state_e            w_next;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [PH_W-1:0]   r_last;
  logic [PH_W-1:0]   r_phase;
  logic [DATA_W-1:0] r_up_data;
  logic              r_underrun;
  logic [7:0]        r_ur_cnt;

  logic [CNT_W-1:0]  w_count;
  logic [DATA_W-1:0] w_head;
  logic              w_empty;
  logic              w_active;
  logic              w_tick;
  logic              w_ph0;
  logic              w_last;
  logic              w_pop;
  logic              w_push;
  logic              w_ur;
  logic              w_busy;
  logic              w_ready;
  logic              w_to_idle;
  logic              w_to_run;

  assign w_empty  = (w_count == '0);
  assign w_busy   = (r_state != ST_IDLE);
  assign w_ready  = w_busy && (w_count != CNT_FULL);
  assign w_push   = s_valid && w_ready;
  assign w_active = (r_state == ST_RUN) ||
                    (r_state == ST_STOPPING);
  assign w_tick   = w_active && (r_div_cnt == r_div);
  assign w_ph0    = w_tick && (r_phase == '0);
  assign w_last   = w_tick && (r_phase == r_last);
  assign w_pop    = w_ph0 && !w_empty;
  assign w_ur     = w_ph0 && w_empty;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (start) w_next = ST_PRIME;
      ST_PRIME:
        if (stop)          w_next = ST_IDLE;
        else if (!w_empty) w_next = ST_RUN;
      ST_RUN:
        if (stop) w_next = ST_STOPPING;
      ST_STOPPING:
        if (w_last) w_next = ST_IDLE;
      default:
        w_next = ST_IDLE;
    endcase
  end

  assign w_to_idle = w_busy && (w_next == ST_IDLE);
  assign w_to_run  = (r_state == ST_PRIME) &&
                     (w_next == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Config is frozen for the whole run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_last <= 4'd1;
    end else if ((r_state == ST_IDLE) && start) begin
      r_div  <= cfg_div;
      r_last <= ratio_last(cfg_ratio);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_phase   <= '0;
    end else if (w_to_idle || w_to_run) begin
      r_div_cnt <= '0;
      r_phase   <= '0;
    end else if (w_active) begin
      if (w_tick) begin
        r_div_cnt <= '0;
        if (r_phase == r_last) r_phase <= '0;
        else r_phase <= r_phase + PH_W'(1);
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  // Empty slot on a load tick is muted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_up_data <= '0;
    else if (w_ph0) r_up_data <= w_pop ? w_head : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= 1'b0;
      r_ur_cnt   <= '0;
    end else if (clr_underrun) begin
      r_underrun <= 1'b0;
      r_ur_cnt   <= '0;
    end else if (w_ur) begin
      r_underrun <= 1'b1;
      if (r_ur_cnt != 8'hFF)
        r_ur_cnt <= r_ur_cnt + 8'd1;
    end
  end

  interp_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (w_to_idle),
    .push  (w_push),
    .din   (s_data),
    .pop   (w_pop),
    .count (w_count),
    .head  (w_head)
  );

  assign s_ready      = w_ready;
  assign busy         = w_busy;
  assign up_en        = w_tick;
  assign up_load      = w_ph0;
  assign up_data      = r_up_data;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_ur_cnt;

endmodule
